// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage core pipeline registers: NOP encoding and the
// per-boundary payload structs that size each pipe_stage_chain instance.
package pipe_pkg;

    localparam logic [31:0] NOOP_INST = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [4:0]  ZERO_REG  = 5'd0;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSll,
        AluSrl,
        AluSra,
        AluSlt,
        AluSltu,
        AluPass
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One elastic pipeline register: loads from upstream when it can hand its content on,
// holds otherwise; flush empties it and parks NOP in the payload.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          DATA_W = 32,
    parameter logic [DATA_W-1:0]    NOP    = DATA_W'(NOOP_INST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic              rdy_down,
    input  logic              flush,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              rdy_up,
    output logic              nxt_valid
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign rdy_up = !valid_q || rdy_down;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = NOP;
        end else if (rdy_up) begin
            valid_d = up_valid;
            data_d  = up_valid ? up_data : NOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid     = valid_q;
    assign data      = data_q;
    assign nxt_valid = valid_d;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH pipeline registers with valid/ready backpressure, bubble
// collapsing, per-stage flush, occupancy and saturating stall-cycle counter.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] NOP_VALUE = NOOP_INST,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic [DEPTH-1:0]           flush_vec,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [DEPTH*DATA_W-1:0]    stage_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_cycles,
    input  logic                       clr_stats
);

    localparam int unsigned       OCC_W = $clog2(DEPTH + 1);
    localparam int                LAST  = int'(DEPTH) - 1;
    localparam logic [DATA_W-1:0] NOP   = DATA_W'(NOP_VALUE);

    if (DEPTH < 1 || DATA_W < 1) begin : g_bad_param
        $fatal(1, "pipe_stage_chain: DEPTH and DATA_W must both be >= 1");
    end

    logic [DEPTH-1:0]  valid_vec;
    logic [DEPTH-1:0]  nxt_valid_vec;
    logic [DATA_W-1:0] data_arr [DEPTH];

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        logic              up_valid;
        logic [DATA_W-1:0] up_data;
        logic              rdy_dn;
        logic              rdy_up;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_body
            // An item leaving a flushed stage is killed, not forwarded.
            assign up_valid = valid_vec[i-1] && !flush_vec[i-1];
            assign up_data  = data_arr[i-1];
        end

        if (i == LAST) begin : g_tail
            assign rdy_dn = out_ready;
        end else begin : g_link
            assign rdy_dn = g_stage[i+1].rdy_up;
        end

        pipe_stage_reg #(
            .DATA_W (DATA_W),
            .NOP    (NOP)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .up_valid  (up_valid),
            .up_data   (up_data),
            .rdy_down  (rdy_dn),
            .flush     (flush_vec[i]),
            .valid     (valid_vec[i]),
            .data      (data_arr[i]),
            .rdy_up    (rdy_up),
            .nxt_valid (nxt_valid_vec[i])
        );

        assign stage_data[i*DATA_W +: DATA_W] = data_arr[i];
    end

    assign in_ready    = g_stage[0].rdy_up;
    assign out_valid   = valid_vec[LAST];
    assign out_data    = data_arr[LAST];
    assign stage_valid = valid_vec;

    // Occupancy tracks the next-state valid vector so it lines up with stage_valid.
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = '0;
        for (int j = 0; j < int'(DEPTH); j++) begin
            occ_d = occ_d + OCC_W'(nxt_valid_vec[j]);
        end
    end

    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (clr_stats) begin
            stall_d = '0;
        end else if (in_valid && !in_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= '0;
            stall_q <= '0;
        end else begin
            occ_q   <= occ_d;
            stall_q <= stall_d;
        end
    end

    assign occupancy    = occ_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: scoreboard queue of accepted payloads, popped on
// each output transfer, plus targeted checks of stall, flush and reset behaviour.
module tb_pipe_stage_chain;

    localparam int          DEPTH  = 4;
    localparam int          DATA_W = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [DEPTH-1:0]           flush_vec;
    logic [DEPTH-1:0]           stage_valid;
    logic [DEPTH*DATA_W-1:0]    stage_data;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic [CNT_W-1:0]           stall_cycles;
    logic                       clr_stats;

    pipe_stage_chain #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .NOP_VALUE (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .flush_vec    (flush_vec),
        .stage_valid  (stage_valid),
        .stage_data   (stage_data),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles),
        .clr_stats    (clr_stats)
    );

    always #5 clk = ~clk;

    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] sb[$];
    bit                drop_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] slot(input int i);
        return stage_data[i*DATA_W +: DATA_W];
    endfunction

    // Sample handshakes just before the edge, advance one cycle, update the scoreboard.
    task automatic step();
        logic              acc_in;
        logic              acc_out;
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] dout;
        #1;
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready;
        din     = in_data;
        dout    = out_data;
        if (acc_out) begin
            check("sb_output_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) check("sb_out_data", 64'(dout), 64'(sb.pop_front()));
        end
        @(posedge clk);
        #1;
        if (acc_in && !drop_in) sb.push_back(din);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush_vec = '0;
        clr_stats = 1'b0;
        drop_in   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        flush_vec = '0; clr_stats = 1'b0; drop_in = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'(NOP));
        check("rst_stage_valid", 64'(stage_valid), 64'd0);
        check("rst_stage_data", 64'(stage_data[63:0]), {NOP, NOP});
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_stall", 64'(stall_cycles), 64'd0);

        // 1: streaming 1..5 with out_ready high
        do_reset();
        check("t1_in_ready_after_rst", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            in_valid = (k <= 5);
            in_data  = DATA_W'(k);
            step();
            check("t1_out_valid", 64'(out_valid), 64'(k >= 4 && k <= 8));
        end
        check("t1_sb_empty", 64'(sb.size()), 64'd0);
        check("t1_stall", 64'(stall_cycles), 64'd0);

        // 2: fill while stalled, count stall cycles, release
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = DATA_W'(32'hA + k);
            step();
        end
        check("t2_occupancy_full", 64'(occupancy), 64'd4);
        check("t2_in_ready_full", 64'(in_ready), 64'd0);
        check("t2_stage_valid", 64'(stage_valid), 64'hF);
        in_data = 32'hE;
        repeat (10) step();
        check("t2_stall_10", 64'(stall_cycles), 64'd10);
        out_ready = 1'b1;
        #1;
        check("t2_in_ready_release", 64'(in_ready), 64'd1);
        check("t2_first_out", 64'(out_data), 64'hA);
        step();
        drain(6);
        check("t2_stall_hold", 64'(stall_cycles), 64'd10);

        // 3: bubble collapse behind a stalled head item
        do_reset();
        in_valid = 1'b1; in_data = 32'h7;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("t3_head_only", 64'(stage_valid), 64'b1000);
        in_valid = 1'b1; in_data = 32'h8;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("t3_stage_valid", 64'(stage_valid), 64'b1100);
        check("t3_stage2", 64'(slot(2)), 64'h8);
        check("t3_stage3", 64'(slot(3)), 64'h7);
        check("t3_occupancy", 64'(occupancy), 64'd2);
        check("t3_in_ready", 64'(in_ready), 64'd1);
        drain(4);

        // 4: flush younger stages while the head transfers out
        do_reset();
        in_valid = 1'b1;
        for (int k = 4; k >= 1; k--) begin
            in_data = DATA_W'(k);
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) check("t4_fill_slot", 64'(slot(i)), 64'(i + 1));
        flush_vec = 4'b0111; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h5; drop_in = 1'b1;
        #1;
        check("t4_in_ready_flush", 64'(in_ready), 64'd1);
        step();
        flush_vec = '0; in_valid = 1'b0; drop_in = 1'b0;
        check("t4_stage_valid", 64'(stage_valid), 64'd0);
        check("t4_occupancy", 64'(occupancy), 64'd0);
        for (int i = 0; i < 3; i++) check("t4_flushed_nop", 64'(slot(i)), 64'(NOP));
        check("t4_dropped_items", 64'(sb.size()), 64'd3);
        sb.delete();
        repeat (4) begin
            step();
            check("t4_no_output", 64'(out_valid), 64'd0);
        end

        // 5: stall counter saturation and clear priority
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = DATA_W'(32'h50 + k);
            step();
        end
        repeat (20) step();
        check("t5_saturated", 64'(stall_cycles), 64'd15);
        clr_stats = 1'b1;
        step();
        check("t5_clear", 64'(stall_cycles), 64'd0);
        clr_stats = 1'b0;
        step();
        check("t5_after_clear", 64'(stall_cycles), 64'd1);
        drain(6);

        // 6: asynchronous reset mid-stream
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = DATA_W'(32'h60 + k);
            step();
        end
        #3;
        rst = 1'b1;
        #1;
        check("t6_stage_valid", 64'(stage_valid), 64'd0);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_out_data", 64'(out_data), 64'(NOP));
        check("t6_occupancy", 64'(occupancy), 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        check("t6_in_ready", 64'(in_ready), 64'd1);
        repeat (6) begin
            step();
            check("t6_no_replay", 64'(out_valid), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised elastic pipeline-register chain for the 5-stage core. It replaces the hand-written IF/ID, ID/EX, EX/MEM and MEM/WB always_ff blocks with one reusable chain of DEPTH stages, each DATA_W bits wide. Over the current global-enable scheme it adds:
- valid/ready backpressure with bubble collapsing;
- per-stage flush, e.g. killing younger stages on a taken branch;
- occupancy and stall-cycle observability.

Parameters:
DEPTH, 4, number of register stages (>=1)
DATA_W, 32, payload width per stage
NOP_VALUE, 32'h0000_0013, payload loaded on reset/flush (truncated or zero-extended to DATA_W)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream has an item
in_ready  out  1  chain accepts an item this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  last stage holds an item
out_ready  in  1  downstream consumes the item this cycle
out_data  out  DATA_W  payload of last stage
flush_vec  in  DEPTH  bit i empties stage i at the next edge
stage_valid  out  DEPTH  valid bit of every stage (debug/hazard use)
stage_data  out  DEPTH*DATA_W  flattened payload of every stage; stage i at [i*DATA_W +: DATA_W]
occupancy  out  $clog2(DEPTH+1)  registered count of valid stages
stall_cycles  out  CNT_W  saturating count of cycles with in_valid && !in_ready
clr_stats  in  1  synchronous clear of stall_cycles

Behaviour:
- Stage 0 is fed by the input; stage DEPTH-1 drives the output. out_valid = stage_valid[DEPTH-1]; out_data = stage_data of DEPTH-1.
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !valid[i] || rdy[i+1].
  - in_ready = rdy[0].
  - An empty stage accepts even when downstream is stalled (bubble collapse).
- Stage i update at posedge, in priority order:
  1. flush_vec[i] -> valid[i] <= 0, data[i] <= NOP_VALUE.
  2. else if rdy[i] -> valid[i] <= upstream valid, data[i] <= upstream data. Upstream of stage 0 is in_valid/in_data.
     - When the upstream is not valid, data is still loaded as NOP_VALUE, so no stale payload remains.
  3. else hold.
- Flushed stage and the handshake:
  - The flushed stage still presents its normal rdy[i] upstream.
  - An item transferred into a flushed stage in that cycle is dropped. The upstream sender considers it consumed.
  - The item previously held in the flushed stage is dropped, whether or not it also moved downstream that cycle.
- Simultaneous out_ready and flush_vec[DEPTH-1]: the output transfer completes (out_valid was 1 this cycle); only the stage's new content is killed.
- Latency: an item accepted at edge t is visible at out_valid after edge t+DEPTH-1, provided no stall. Throughput is 1 item/cycle when out_ready is held high.
- Full chain (all valid) with out_ready=0: in_ready=0, all stages hold, stall_cycles increments while in_valid=1. It saturates at 2^CNT_W-1 and never wraps.
- occupancy is the registered popcount of the next-state valid vector; it always equals the popcount of stage_valid.
- clr_stats has priority over the increment: the counter goes to 0 that cycle.
- Reset (async assert, values held while rst=1):
  - all valid = 0 and all data = NOP_VALUE, so out_valid = 0 and out_data = NOP_VALUE;
  - occupancy = 0, stall_cycles = 0;
  - in_ready = 1 once out of reset, since the chain is empty.
- Reset mid-operation: all in-flight items are lost; nothing is replayed.
- Elaboration: DEPTH < 1 or DATA_W < 1 is a $fatal.

Decomposition:
- Shared package pipe_pkg:
  - NOOP_INST constant;
  - ZERO_REG constant;
  - typedefs for the per-boundary payload structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t), so each boundary instantiates this chain with DATA_W = $bits(struct).
- Sub-module pipe_stage_reg: one stage, with inputs valid/data/rdy_down/flush and outputs valid/data/rdy_up. It is generated DEPTH times. Counters live in the top.

Test Plan:
1. Reset, then in_valid=1 with data 1,2,3,4,5 on consecutive cycles, out_ready=1, DEPTH=4 -> out_data sequence 1..5 starting 3 cycles after the first accept; out_valid continuous; stall_cycles=0.
2. Fill with 0xA,0xB,0xC,0xD with out_ready=0 -> occupancy=4, in_ready=0; hold in_valid=1 for 10 cycles -> stall_cycles=10; raise out_ready -> 0xA appears first and in_ready returns to 1 the same cycle.
3. Bubble collapse: only stage 3 holds 0x7 and out_ready=0; send 0x8 -> it advances to stage 2 and stops behind 0x7; occupancy=2.
4. Flush: chain holds 1,2,3,4 (4 at output); assert flush_vec=4'b0111 for one cycle with out_ready=1 -> 4 delivered, stages 0-2 empty with data 0x13, occupancy=0 next cycle; incoming item 5 in the same cycle is dropped.
5. Saturation: CNT_W=4, stall for 20 cycles -> stall_cycles=15; pulse clr_stats while still stalled -> 0 in that cycle, 1 after the next stalled cycle.
6. Assert rst asynchronously mid-stream between edges -> stage_valid=0, out_data=0x13 immediately; no item from before reset ever reaches the output.
